cpu_mult_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the Nios II datapath. It returns the full double-width product of two WIDTH-bit operands. Each operand is independently selectable as signed or unsigned, covering mul, mulxss, mulxsu and mulxuu. Internally it forms four half-width partial products in hardware multipliers and sums them in a registered adder stage. A valid/ready handshake with whole-pipe stall and a synchronous flush let it sit between the E and W stages under pipeline backpressure.

---
 rtl/cpu_mult_pipe.sv | 113 +++++++++++
 tb/tb_cpu_mult_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mult_pipe.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier with per-operand signedness.
// Four half-width partial products, a registered sum, optional output delay stages.
module cpu_mult_pipe #(
  parameter int WIDTH        = 32,
  parameter int EXTRA_STAGES = 0,
  parameter int TAG_W        = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sign_a,
  input  logic                 in_sign_b,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam int PPW  = WIDTH + 2;
  localparam int NQ   = EXTRA_STAGES + 1;

  logic                  advance;
  logic [WIDTH:0]        a_ext, b_ext;
  logic [WIDTH-1:0]      a_lo_u, b_lo_u;
  logic signed [PPW-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;

  logic [WIDTH-1:0]      pp_ll_d, pp_ll_q;
  logic signed [PPW-1:0] pp_lh_d, pp_lh_q;
  logic signed [PPW-1:0] pp_hl_d, pp_hl_q;
  logic signed [PPW-1:0] pp_hh_d, pp_hh_q;
  logic                  v1_q;
  logic [TAG_W-1:0]      tag1_q;

  logic [PW-1:0]         sum_d;
  logic [PW-1:0]         prod_q [NQ];
  logic [TAG_W-1:0]      tag_q  [NQ];
  logic                  vld_q  [NQ];

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Extra MSB carries the sign only when the operand is declared signed.
  assign a_ext = {in_sign_a & in_a[WIDTH-1], in_a};
  assign b_ext = {in_sign_b & in_b[WIDTH-1], in_b};

  assign a_lo_u = {{HALF{1'b0}}, a_ext[HALF-1:0]};
  assign b_lo_u = {{HALF{1'b0}}, b_ext[HALF-1:0]};
  assign a_lo_x = {{(HALF+2){1'b0}}, a_ext[HALF-1:0]};
  assign b_lo_x = {{(HALF+2){1'b0}}, b_ext[HALF-1:0]};
  assign a_hi_x = {{(HALF+1){a_ext[WIDTH]}}, a_ext[WIDTH:HALF]};
  assign b_hi_x = {{(HALF+1){b_ext[WIDTH]}}, b_ext[WIDTH:HALF]};

  assign pp_ll_d = a_lo_u * b_lo_u;
  assign pp_lh_d = a_lo_x * b_hi_x;
  assign pp_hl_d = a_hi_x * b_lo_x;
  assign pp_hh_d = a_hi_x * b_hi_x;

  assign sum_d = {{WIDTH{1'b0}}, pp_ll_q}
               + ({{(PW-PPW){pp_lh_q[PPW-1]}}, pp_lh_q} << HALF)
               + ({{(PW-PPW){pp_hl_q[PPW-1]}}, pp_hl_q} << HALF)
               + ({{(PW-PPW){pp_hh_q[PPW-1]}}, pp_hh_q} << WIDTH);

  // Data moves only on advance; flush clears valids but leaves data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      tag1_q  <= '0;
      v1_q    <= 1'b0;
      for (int i = 0; i < NQ; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      if (advance) begin
        pp_ll_q   <= pp_ll_d;
        pp_lh_q   <= pp_lh_d;
        pp_hl_q   <= pp_hl_d;
        pp_hh_q   <= pp_hh_d;
        tag1_q    <= in_tag;
        prod_q[0] <= sum_d;
        tag_q[0]  <= tag1_q;
        for (int i = 1; i < NQ; i++) begin
          prod_q[i] <= prod_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
      if (flush) begin
        v1_q <= 1'b0;
        for (int i = 0; i < NQ; i++) vld_q[i] <= 1'b0;
      end else if (advance) begin
        v1_q     <= in_valid;
        vld_q[0] <= v1_q;
        for (int i = 1; i < NQ; i++) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[NQ-1];
  assign out_prod  = prod_q[NQ-1];
  assign out_tag   = tag_q[NQ-1];

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Bench for cpu_mult_pipe: three instances (32/L2, 16/L4, 8/L4) with directed
// vectors and a queue-based reference model checked every cycle.
module tb_cpu_mult_pipe;

  typedef struct packed {
    logic [63:0] p;
    logic [4:0]  t;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid  [3];
  logic        in_ready_w[3];
  logic [31:0] in_a      [3];
  logic [31:0] in_b      [3];
  logic        in_sign_a [3];
  logic        in_sign_b [3];
  logic [4:0]  in_tag    [3];
  logic        flush     [3];
  logic        ov        [3];
  logic        out_ready [3];
  logic [63:0] prod_w    [3];
  logic [4:0]  tag_w     [3];

  exp_t q0[$], q1[$], q2[$];
  int   pops[3];
  int   accs[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W  = (gi == 0) ? 32 : ((gi == 1) ? 16 : 8);
    localparam int ES = (gi == 0) ? 0 : 2;
    logic [2*W-1:0] p;
    cpu_mult_pipe #(.WIDTH(W), .EXTRA_STAGES(ES), .TAG_W(5)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready_w[gi]),
      .in_a      (in_a[gi][W-1:0]),
      .in_b      (in_b[gi][W-1:0]),
      .in_sign_a (in_sign_a[gi]),
      .in_sign_b (in_sign_b[gi]),
      .in_tag    (in_tag[gi]),
      .flush     (flush[gi]),
      .out_valid (ov[gi]),
      .out_ready (out_ready[gi]),
      .out_prod  (p),
      .out_tag   (tag_w[gi])
    );
    assign prod_w[gi] = 64'(p);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int id);
    return (id == 0) ? 32 : ((id == 1) ? 16 : 8);
  endfunction

  // Reference: extend each operand to 128 bits per its sign flag, multiply, truncate.
  function automatic logic [127:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input int w);
    logic signed [127:0] ax, bx, pr;
    logic [127:0]        m;
    m  = (128'd1 << w) - 128'd1;
    ax = $signed({96'd0, a} & m);
    bx = $signed({96'd0, b} & m);
    if (sa && a[w-1]) ax = ax - $signed(128'd1 << w);
    if (sb && b[w-1]) bx = bx - $signed(128'd1 << w);
    pr = ax * bx;
    m  = (128'd1 << (2 * w)) - 128'd1;
    return pr & m;
  endfunction

  function automatic int q_size(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int id);
    case (id)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int id);
    case (id)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int id);
    case (id)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Sampled at the falling edge: these are the values the next rising edge acts on.
  task automatic mon_all();
    exp_t         e;
    logic [127:0] r;
    for (int id = 0; id < 3; id++) begin
      if (!reset_n) begin
        q_clear(id);
      end else begin
        check_eq($sformatf("d%0d_in_ready", id), 128'(in_ready_w[id]),
                 128'(!ov[id] || out_ready[id]));
        if (ov[id]) begin
          if (q_size(id) == 0) begin
            check_eq($sformatf("d%0d_spurious_out", id), 128'(ov[id]), 128'd0);
          end else begin
            e = q_front(id);
            check_eq($sformatf("d%0d_prod", id), 128'(prod_w[id]), 128'(e.p));
            check_eq($sformatf("d%0d_tag", id), 128'(tag_w[id]), 128'(e.t));
            if (out_ready[id]) begin
              q_pop(id);
              pops[id]++;
            end
          end
        end
        if (in_valid[id] && in_ready_w[id]) begin
          r   = ref_prod(in_a[id], in_b[id], in_sign_a[id], in_sign_b[id], width_of(id));
          e.p = r[63:0];
          e.t = in_tag[id];
          q_push(id, e);
          accs[id]++;
        end
        if (flush[id]) q_clear(id);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input logic [4:0] t);
    in_valid[id]  = v;
    in_a[id]      = a;
    in_b[id]      = b;
    in_sign_a[id] = sa;
    in_sign_b[id] = sb;
    in_tag[id]    = t;
  endtask

  task automatic rand_in(input int id, input logic v);
    set_in(id, v, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
  endtask

  // One operand pair; result must be absent for lat-1 cycles, then present with exp.
  task automatic directed(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp, input int lat);
    out_ready[id] = 1'b1;
    set_in(id, 1'b1, a, b, sa, sb, 5'h15);
    tick();
    in_valid[id] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check_eq($sformatf("d%0d_early_valid", id), 128'(ov[id]), 128'd0);
      tick();
    end
    check_eq($sformatf("d%0d_lat_valid", id), 128'(ov[id]), 128'd1);
    check_eq($sformatf("d%0d_dir_prod", id), 128'(prod_w[id]), 128'(exp));
    check_eq($sformatf("d%0d_dir_tag", id), 128'(tag_w[id]), 128'h15);
    $display("txn d%0d a=%h b=%h sa=%0d sb=%0d prod=%h", id, a, b, sa, sb, prod_w[id]);
    tick();
  endtask

  initial begin
    int p0, a0;
    for (int id = 0; id < 3; id++) begin
      set_in(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      flush[id]     = 1'b0;
      out_ready[id] = 1'b0;
      pops[id]      = 0;
      accs[id]      = 0;
    end
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int id = 0; id < 3; id++) begin
      check_eq($sformatf("d%0d_rst_valid", id), 128'(ov[id]), 128'd0);
      check_eq($sformatf("d%0d_rst_prod", id), 128'(prod_w[id]), 128'd0);
      check_eq($sformatf("d%0d_rst_tag", id), 128'(tag_w[id]), 128'd0);
      check_eq($sformatf("d%0d_rst_ready", id), 128'(in_ready_w[id]), 128'd1);
      out_ready[id] = 1'b1;
    end
    tick();

    // Sign modes at WIDTH=32, latency 2
    directed(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 2);
    directed(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001, 2);
    directed(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001, 2);
    directed(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF00000001, 2);
    directed(0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 2);
    directed(0, 32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEB, 2);
    directed(0, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h0000000100000000, 2);
    directed(0, 32'h00000000, 32'h80000000, 1'b1, 1'b1, 64'h0000000000000000, 2);
    // Latency 4 at the narrow widths
    directed(2, 32'h000000FF, 32'h000000FF, 1'b1, 1'b1, 64'h0001, 4);
    directed(2, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 64'hFE01, 4);
    directed(2, 32'h00000080, 32'h0000007F, 1'b1, 1'b0, 64'hC080, 4);
    directed(1, 32'h00008000, 32'h00008000, 1'b1, 1'b1, 64'h40000000, 4);

    // Back-to-back streaming: one result per cycle once the pipe fills
    p0 = pops[0];
    for (int i = 0; i < 100; i++) begin
      rand_in(0, 1'b1);
      tick();
      if (i >= 1) check_eq("d0_stream_valid", 128'(ov[0]), 128'd1);
    end
    in_valid[0] = 1'b0;
    tick();
    check_eq("d0_stream_last", 128'(ov[0]), 128'd1);
    tick();
    check_eq("d0_stream_idle", 128'(ov[0]), 128'd0);
    check_eq("d0_stream_count", 128'(pops[0] - p0), 128'd100);

    // Random backpressure
    p0 = pops[0];
    a0 = accs[0];
    for (int i = 0; i < 400; i++) begin
      rand_in(0, 1'($urandom));
      out_ready[0] = 1'($urandom);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    repeat (6) tick();
    check_eq("d0_bp_count", 128'(pops[0] - p0), 128'(accs[0] - a0));
    check_eq("d0_bp_drained", 128'(q_size(0)), 128'd0);

    // Flush while stalled
    out_ready[0] = 1'b0;
    set_in(0, 1'b1, 32'h7, 32'hFFFFFFFD, 1'b1, 1'b1, 5'h0A);
    tick();
    in_valid[0] = 1'b0;
    tick();
    check_eq("d0_stall_valid", 128'(ov[0]), 128'd1);
    check_eq("d0_stall_ready", 128'(in_ready_w[0]), 128'd0);
    tick();
    check_eq("d0_stall_hold", 128'(prod_w[0]), 128'hFFFFFFFFFFFFFFEB);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    check_eq("d0_flush_valid", 128'(ov[0]), 128'd0);
    check_eq("d0_flush_ready", 128'(in_ready_w[0]), 128'd1);
    out_ready[0] = 1'b1;
    tick();

    // Three in flight, fourth accepted with flush: nothing emerges
    p0 = pops[1];
    for (int i = 0; i < 3; i++) begin
      rand_in(1, 1'b1);
      tick();
    end
    rand_in(1, 1'b1);
    flush[1] = 1'b1;
    tick();
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    repeat (6) tick();
    check_eq("d1_flush_none", 128'(pops[1] - p0), 128'd0);
    directed(1, 32'h00001234, 32'h00000010, 1'b0, 1'b0, 64'h00012340, 4);

    // Reset with two ops in flight
    p0 = pops[1];
    rand_in(1, 1'b1);
    tick();
    rand_in(1, 1'b1);
    tick();
    in_valid[1] = 1'b0;
    reset_n     = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check_eq("d1_rst_none", 128'(pops[1] - p0), 128'd0);
    check_eq("d1_rst_idle", 128'(ov[1]), 128'd0);

    // WIDTH=16 random operands, all sign modes
    p0 = pops[1];
    for (int i = 0; i < 300; i++) begin
      rand_in(1, 1'b1);
      tick();
    end
    in_valid[1] = 1'b0;
    repeat (6) tick();
    check_eq("d1_rand_count", 128'(pops[1] - p0), 128'd300);

    // WIDTH=8 exhaustive operands, sign mode varied across the sweep
    p0 = pops[2];
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      set_in(2, 1'b1, {24'd0, iv[15:8]}, {24'd0, iv[7:0]},
             iv[8] ^ iv[1], iv[0] ^ iv[9], 5'(iv[4:0]));
      tick();
    end
    in_valid[2] = 1'b0;
    repeat (6) tick();
    check_eq("d2_exh_count", 128'(pops[2] - p0), 128'd65536);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
